traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Parametrised N-approach intersection controller that serves vehicle phases round-robin, with yellow and all-red clearance between phases. Pedestrian requests are latched and served once per cycle through an exclusive walk interval. A night mode flashes yellow on all approaches. The block drives lamp outputs and a BCD countdown for the board's two 7-segment digits, and is the multi-approach generalisation of the board-level traffic-light top.

Parameters:
CLK_HZ, 50_000_000, clk cycles per 1 s tick (>=2)
NPHASE, 4, number of vehicle approaches/phases (2..8)
T_RST, 3, seconds all-red after reset
T_GREEN, 18, seconds green per phase
T_YELLOW, 4, seconds yellow per phase
T_ALLRED, 2, seconds all-red clearance
T_PED, 5, seconds pedestrian walk
All T_* in 1..99.

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
ped_req  in  1  pedestrian request, level or pulse, synchronous to clk
night_mode  in  1  request for flashing-yellow operation
veh_red  out  NPHASE  red lamp per approach
veh_yellow  out  NPHASE  yellow lamp per approach
veh_green  out  NPHASE  green lamp per approach
ped_walk  out  1  walk lamp
ped_dont_walk  out  1  don't-walk lamp
ped_pending  out  1  latched pedestrian request (waiting LED)
phase  out  $clog2(NPHASE)  index of current/last served phase
state_code  out  3  RST=0, GREEN=1, YELLOW=2, ALLRED=3, PED_WALK=4, PED_CLR=5, FLASH=6
tick  out  1  one-cycle 1 s strobe
cnt_tens  out  4  BCD tens of seconds remaining
cnt_units  out  4  BCD units of seconds remaining

Behaviour:
- Divider counts 0..CLK_HZ-1 and wraps. tick=1 for exactly the cycle where count==CLK_HZ-1.
- sec_left: width $clog2(99+1). On state entry, loaded with T_state-1.
- Transition rule: on a clk edge with tick=1 and sec_left==0, the state and the new sec_left update on the same edge. Each state therefore lasts exactly T_state*CLK_HZ cycles. On a tick with sec_left!=0, sec_left decrements.
- Reset values: state RST, sec_left=T_RST-1, divider 0, phase=NPHASE-1, ped_pending=0, all veh_red=1, yellow/green=0, ped_dont_walk=1, ped_walk=0, tick=0.
- RST -> GREEN with phase=0.
- GREEN(p) -> YELLOW(p).
- YELLOW(p) -> ALLRED.
- ALLRED exit, evaluated in priority order:
  - phase==NPHASE-1 and ped_pending: go to PED_WALK.
  - else night_mode: go to FLASH.
  - else: GREEN((phase+1) mod NPHASE), phase updates.
- PED_WALK (T_PED) -> PED_CLR (T_ALLRED).
- PED_CLR -> FLASH if night_mode, else GREEN(0).
- FLASH: sec_left held at 0; flash_on toggles each tick, starting at 1 on entry.
- FLASH exit: at the first tick with night_mode=0, go to ALLRED and set phase=NPHASE-1, so the next green is phase 0.
- Lamps:
  - GREEN(p): green[p]=1, all other approaches red.
  - YELLOW(p): yellow[p]=1, others red.
  - RST/ALLRED/PED_WALK/PED_CLR: all red.
  - FLASH: veh_yellow = all flash_on, veh_red=0, green=0.
  - ped_walk=1 only in PED_WALK. ped_dont_walk = ~ped_walk, except in FLASH where both are 0.
  - Exactly one lamp colour per approach outside FLASH. Never two greens at once.
- ped_pending:
  - Set on any cycle with ped_req=1, except in PED_WALK or FLASH.
  - Cleared on the PED_WALK entry edge and on the FLASH entry edge.
  - Clear wins over a simultaneous set.
- Countdown value = sec_left+1 outside FLASH; cnt_tens = value/10, cnt_units = value%10. In FLASH both digits = 4'hF (blank code).
- All outputs are registered or a function of registered state only. No combinational path from inputs to outputs.
- Reset mid-operation returns to reset values immediately (asynchronous); the first tick comes CLK_HZ cycles after reset release.

Test Plan:
Bench params: CLK_HZ=4, NPHASE=3, T_RST=2, T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_PED=3.
1. Release reset, no requests -> all red for 8 cycles; green[0] for 20 cycles, yellow[0] for 8, all-red for 4; then green[1]. Full cycle 96 cycles back to green[0]; tick period 4.
2. Pulse ped_req one cycle during green[1] -> ped_pending=1 immediately. After yellow[2]+allred: ped_walk for 12 cycles, then all-red 4, then green[0]. ped_pending clears on walk entry.
3. Hold ped_req high through PED_WALK -> ped_pending stays 0 during walk and sets on the first PED_CLR cycle.
4. Assert night_mode during green[0] -> phase completes; at ALLRED exit state_code=6, veh_yellow toggles 111/000 every 4 cycles, digits=F/F. Deassert -> 4 cycles all-red, then green[0].
5. Countdown check: at green entry cnt_tens=0, cnt_units=5, decrementing to 1 each tick. Re-run with T_GREEN=18 -> 1/8 at entry.
6. Assert reset during yellow[1] -> outputs return to the all-red reset values in the same cycle. The sequence restarts exactly as in scenario 1.

Source files
------------

// File: rtl/traffic_phase_ctrl_if.sv
// Lamp, pedestrian and countdown signals of the intersection controller.
// The bench or board logic is the master; the controller is the slave.
interface traffic_phase_ctrl_if #(
  parameter int NPHASE = 4
);
  localparam int PW = $clog2(NPHASE);

  logic              ped_req;
  logic              night_mode;
  logic [NPHASE-1:0] veh_red;
  logic [NPHASE-1:0] veh_yellow;
  logic [NPHASE-1:0] veh_green;
  logic              ped_walk;
  logic              ped_dont_walk;
  logic              ped_pending;
  logic [PW-1:0]     phase;
  logic [2:0]        state_code;
  logic              tick;
  logic [3:0]        cnt_tens;
  logic [3:0]        cnt_units;

  modport master (
    output ped_req, night_mode,
    input  veh_red, veh_yellow, veh_green, ped_walk, ped_dont_walk,
           ped_pending, phase, state_code, tick, cnt_tens, cnt_units
  );

  modport slave (
    input  ped_req, night_mode,
    output veh_red, veh_yellow, veh_green, ped_walk, ped_dont_walk,
           ped_pending, phase, state_code, tick, cnt_tens, cnt_units
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-approach traffic controller with clearance intervals, an
// exclusive pedestrian walk once per cycle, night flashing and a BCD countdown.
module traffic_phase_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int NPHASE   = 4,
  parameter int T_RST    = 3,
  parameter int T_GREEN  = 18,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 5
) (
  input  logic clk,
  input  logic reset,
  traffic_phase_ctrl_if.slave bus
);
  localparam int PW = $clog2(NPHASE);
  localparam int SW = $clog2(99 + 1);
  localparam int DW = $clog2(CLK_HZ);

  localparam logic [2:0] S_RST      = 3'd0;
  localparam logic [2:0] S_GREEN    = 3'd1;
  localparam logic [2:0] S_YELLOW   = 3'd2;
  localparam logic [2:0] S_ALLRED   = 3'd3;
  localparam logic [2:0] S_PED_WALK = 3'd4;
  localparam logic [2:0] S_PED_CLR  = 3'd5;
  localparam logic [2:0] S_FLASH    = 3'd6;

  localparam logic [DW-1:0]     DIV_MAX   = DW'(CLK_HZ - 1);
  localparam logic [PW-1:0]     LAST      = PW'(NPHASE - 1);
  localparam logic [SW-1:0]     LD_RST    = SW'(T_RST - 1);
  localparam logic [SW-1:0]     LD_GREEN  = SW'(T_GREEN - 1);
  localparam logic [SW-1:0]     LD_YELLOW = SW'(T_YELLOW - 1);
  localparam logic [SW-1:0]     LD_ALLRED = SW'(T_ALLRED - 1);
  localparam logic [SW-1:0]     LD_PED    = SW'(T_PED - 1);
  localparam logic [NPHASE-1:0] ALL_ON    = {NPHASE{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [SW-1:0]     sec_q, sec_d;
  logic [DW-1:0]     div_q, div_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              flash_q, flash_d;
  logic              pend_q, pend_d;
  logic              clr_pend;
  logic              tick;
  logic [NPHASE-1:0] onehot;
  logic [SW-1:0]     cnt_val;

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    phase_d  = phase_q;
    flash_d  = flash_q;
    clr_pend = 1'b0;
    div_d    = tick ? '0 : div_q + DW'(1);

    if (tick) begin
      if (state_q == S_FLASH) begin
        if (!bus.night_mode) begin
          state_d = S_ALLRED;
          sec_d   = LD_ALLRED;
          phase_d = LAST;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (sec_q != '0) begin
        sec_d = sec_q - SW'(1);
      end else begin
        case (state_q)
          S_RST: begin
            state_d = S_GREEN;
            sec_d   = LD_GREEN;
            phase_d = '0;
          end
          S_GREEN: begin
            state_d = S_YELLOW;
            sec_d   = LD_YELLOW;
          end
          S_YELLOW: begin
            state_d = S_ALLRED;
            sec_d   = LD_ALLRED;
          end
          // The walk is only offered after the last approach, so once per cycle.
          S_ALLRED: begin
            if (phase_q == LAST && pend_q) begin
              state_d  = S_PED_WALK;
              sec_d    = LD_PED;
              clr_pend = 1'b1;
            end else if (bus.night_mode) begin
              state_d  = S_FLASH;
              sec_d    = '0;
              flash_d  = 1'b1;
              clr_pend = 1'b1;
            end else begin
              state_d = S_GREEN;
              sec_d   = LD_GREEN;
              phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
            end
          end
          S_PED_WALK: begin
            state_d = S_PED_CLR;
            sec_d   = LD_ALLRED;
          end
          S_PED_CLR: begin
            if (bus.night_mode) begin
              state_d  = S_FLASH;
              sec_d    = '0;
              flash_d  = 1'b1;
              clr_pend = 1'b1;
            end else begin
              state_d = S_GREEN;
              sec_d   = LD_GREEN;
              phase_d = '0;
            end
          end
          default: begin
            state_d = S_RST;
            sec_d   = LD_RST;
          end
        endcase
      end
    end

    pend_d = pend_q;
    if (clr_pend) begin
      pend_d = 1'b0;
    end else if (bus.ped_req && state_q != S_PED_WALK && state_q != S_FLASH) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      sec_q   <= LD_RST;
      div_q   <= '0;
      phase_q <= LAST;
      flash_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      flash_q <= flash_d;
      pend_q  <= pend_d;
    end
  end

  assign onehot  = NPHASE'(1) << phase_q;
  assign cnt_val = sec_q + SW'(1);

  always_comb begin
    bus.veh_red    = ALL_ON;
    bus.veh_yellow = '0;
    bus.veh_green  = '0;
    case (state_q)
      S_GREEN: begin
        bus.veh_green = onehot;
        bus.veh_red   = ~onehot;
      end
      S_YELLOW: begin
        bus.veh_yellow = onehot;
        bus.veh_red    = ~onehot;
      end
      S_FLASH: begin
        bus.veh_red    = '0;
        bus.veh_yellow = flash_q ? ALL_ON : '0;
      end
      default: ;
    endcase
  end

  assign bus.ped_walk      = (state_q == S_PED_WALK);
  assign bus.ped_dont_walk = (state_q != S_PED_WALK) && (state_q != S_FLASH);
  assign bus.ped_pending   = pend_q;
  assign bus.phase         = phase_q;
  assign bus.state_code    = state_q;
  assign bus.tick          = tick;
  // Blank code on both digits while flashing.
  assign bus.cnt_tens      = (state_q == S_FLASH) ? 4'hF : 4'(cnt_val / SW'(10));
  assign bus.cnt_units     = (state_q == S_FLASH) ? 4'hF : 4'(cnt_val % SW'(10));
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: fixed timeline table, hand-written corner
// sequences and random requests checked against an interval-level model.
module tb_traffic_phase_ctrl;
  localparam int CLK_HZ   = 4;
  localparam int NPHASE   = 3;
  localparam int T_RST    = 2;
  localparam int T_GREEN  = 5;
  localparam int T_YELLOW = 2;
  localparam int T_ALLRED = 1;
  localparam int T_PED    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  traffic_phase_ctrl_if #(.NPHASE(NPHASE)) bus ();
  traffic_phase_ctrl_if #(.NPHASE(NPHASE)) bus2 ();

  traffic_phase_ctrl #(
    .CLK_HZ(CLK_HZ), .NPHASE(NPHASE), .T_RST(T_RST), .T_GREEN(T_GREEN),
    .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .T_PED(T_PED)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  traffic_phase_ctrl #(
    .CLK_HZ(CLK_HZ), .NPHASE(NPHASE), .T_RST(T_RST), .T_GREEN(18),
    .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .T_PED(T_PED)
  ) dut18 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which interval we are in and how many clock cycles of it remain.
  int m_state, m_phase, m_rem, m_cyc, m_flash, m_pend;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    int         ph;
    logic [2:0] red;
    logic [2:0] yel;
    logic [2:0] grn;
    logic [3:0] tens;
    logic [3:0] units;
    logic       tk;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at model cycle %0d: got %0h, expected %0h", name, m_cyc, act, exp);
    end
  endtask

  function automatic int dur(input int s);
    case (s)
      0: return T_RST * CLK_HZ;
      1: return T_GREEN * CLK_HZ;
      2: return T_YELLOW * CLK_HZ;
      3: return T_ALLRED * CLK_HZ;
      4: return T_PED * CLK_HZ;
      5: return T_ALLRED * CLK_HZ;
      default: return CLK_HZ;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_phase = NPHASE - 1;
    m_rem   = dur(0);
    m_cyc   = 0;
    m_flash = 0;
    m_pend  = 0;
  endtask

  task automatic model_advance(input bit ped, input bit night);
    bit tk;
    bit set_p;
    bit clr_p;
    int ns;
    tk    = (m_cyc % CLK_HZ) == CLK_HZ - 1;
    set_p = ped && m_state != 4 && m_state != 6;
    clr_p = 0;
    ns    = m_state;
    if (m_state == 6) begin
      if (tk) begin
        if (!night) begin
          ns = 3;
          m_phase = NPHASE - 1;
        end else begin
          m_flash = !m_flash;
        end
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_state)
          0: begin ns = 1; m_phase = 0; end
          1: ns = 2;
          2: ns = 3;
          3: begin
            if (m_phase == NPHASE - 1 && m_pend != 0) ns = 4;
            else if (night) ns = 6;
            else begin ns = 1; m_phase = (m_phase + 1) % NPHASE; end
          end
          4: ns = 5;
          5: begin
            if (night) ns = 6;
            else begin ns = 1; m_phase = 0; end
          end
          default: ns = 0;
        endcase
      end
    end
    if (ns != m_state) begin
      m_rem = dur(ns);
      if (ns == 6) m_flash = 1;
      if (ns == 4 || ns == 6) clr_p = 1;
    end
    m_state = ns;
    if (clr_p) m_pend = 0;
    else if (set_p) m_pend = 1;
    m_cyc++;
  endtask

  task automatic compare_model();
    int all;
    int oh;
    int secs;
    all  = (1 << NPHASE) - 1;
    oh   = 1 << m_phase;
    secs = (m_rem + CLK_HZ - 1) / CLK_HZ;
    check("state_code", 32'(bus.state_code), 32'(m_state));
    check("phase", 32'(bus.phase), 32'(m_phase));
    check("veh_red", 32'(bus.veh_red),
          32'((m_state == 1 || m_state == 2) ? (all & ~oh) : (m_state == 6 ? 0 : all)));
    check("veh_yellow", 32'(bus.veh_yellow),
          32'(m_state == 2 ? oh : (m_state == 6 && m_flash != 0 ? all : 0)));
    check("veh_green", 32'(bus.veh_green), 32'(m_state == 1 ? oh : 0));
    check("ped_walk", 32'(bus.ped_walk), 32'(m_state == 4));
    check("ped_dont_walk", 32'(bus.ped_dont_walk), 32'(m_state != 4 && m_state != 6));
    check("ped_pending", 32'(bus.ped_pending), 32'(m_pend));
    check("tick", 32'(bus.tick), 32'((m_cyc % CLK_HZ) == CLK_HZ - 1));
    check("cnt_tens", 32'(bus.cnt_tens), 32'(m_state == 6 ? 15 : secs / 10));
    check("cnt_units", 32'(bus.cnt_units), 32'(m_state == 6 ? 15 : secs % 10));
  endtask

  task automatic applyStimulus(input bit ped, input bit night);
    @(negedge clk);
    compare_model();
    bus.ped_req    = ped;
    bus.night_mode = night;
    model_advance(ped, night);
  endtask

  task automatic run_to(input int c, input bit ped, input bit night);
    while (m_cyc < c) applyStimulus(ped, night);
  endtask

  // Leaves the bench #1 after the posedge that starts cycle c.
  task automatic at_cycle(input int c, input bit ped, input bit night);
    run_to(c, ped, night);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ped_req    = 1'b0;
    bus.night_mode = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic checkOutput(input vec_t v);
    check("tbl state", 32'(bus.state_code), 32'(v.st));
    check("tbl phase", 32'(bus.phase), 32'(v.ph));
    check("tbl red", 32'(bus.veh_red), 32'(v.red));
    check("tbl yellow", 32'(bus.veh_yellow), 32'(v.yel));
    check("tbl green", 32'(bus.veh_green), 32'(v.grn));
    check("tbl tens", 32'(bus.cnt_tens), 32'(v.tens));
    check("tbl units", 32'(bus.cnt_units), 32'(v.units));
    check("tbl tick", 32'(bus.tick), 32'(v.tk));
  endtask

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      at_cycle(vecs[i].cyc, 1'b0, 1'b0);
      checkOutput(vecs[i]);
    end
  endtask

  initial begin
    bit night;
    bit ped;

    //          cyc  st    ph red     yel     grn     tens  units tick
    vecs[0]  = '{7,   3'd0, 2, 3'b111, 3'b000, 3'b000, 4'd0, 4'd1, 1'b1};
    vecs[1]  = '{8,   3'd1, 0, 3'b110, 3'b000, 3'b001, 4'd0, 4'd5, 1'b0};
    vecs[2]  = '{27,  3'd1, 0, 3'b110, 3'b000, 3'b001, 4'd0, 4'd1, 1'b1};
    vecs[3]  = '{28,  3'd2, 0, 3'b110, 3'b001, 3'b000, 4'd0, 4'd2, 1'b0};
    vecs[4]  = '{36,  3'd3, 0, 3'b111, 3'b000, 3'b000, 4'd0, 4'd1, 1'b0};
    vecs[5]  = '{39,  3'd3, 0, 3'b111, 3'b000, 3'b000, 4'd0, 4'd1, 1'b1};
    vecs[6]  = '{40,  3'd1, 1, 3'b101, 3'b000, 3'b010, 4'd0, 4'd5, 1'b0};
    vecs[7]  = '{72,  3'd1, 2, 3'b011, 3'b000, 3'b100, 4'd0, 4'd5, 1'b0};
    vecs[8]  = '{92,  3'd2, 2, 3'b011, 3'b100, 3'b000, 4'd0, 4'd2, 1'b0};
    vecs[9]  = '{100, 3'd3, 2, 3'b111, 3'b000, 3'b000, 4'd0, 4'd1, 1'b0};
    vecs[10] = '{104, 3'd1, 0, 3'b110, 3'b000, 3'b001, 4'd0, 4'd5, 1'b0};
    vecs[11] = '{107, 3'd1, 0, 3'b110, 3'b000, 3'b001, 4'd0, 4'd5, 1'b1};

    bus.ped_req     = 1'b0;
    bus.night_mode  = 1'b0;
    bus2.ped_req    = 1'b0;
    bus2.night_mode = 1'b0;
    model_reset();

    // Two-digit countdown on the long-green instance.
    do_reset();
    at_cycle(8, 1'b0, 1'b0);
    check("g18 entry tens", 32'(bus2.cnt_tens), 32'd1);
    check("g18 entry units", 32'(bus2.cnt_units), 32'd8);
    at_cycle(40, 1'b0, 1'b0);
    check("g18 ten tens", 32'(bus2.cnt_tens), 32'd1);
    check("g18 ten units", 32'(bus2.cnt_units), 32'd0);
    at_cycle(44, 1'b0, 1'b0);
    check("g18 nine tens", 32'(bus2.cnt_tens), 32'd0);
    check("g18 nine units", 32'(bus2.cnt_units), 32'd9);

    do_reset();
    run_table();

    // Asynchronous reset in the middle of yellow[1].
    do_reset();
    at_cycle(62, 1'b0, 1'b0);
    check("pre-reset state", 32'(bus.state_code), 32'd2);
    reset = 1'b1;
    #1;
    check("rst state", 32'(bus.state_code), 32'd0);
    check("rst red", 32'(bus.veh_red), 32'h7);
    check("rst yellow", 32'(bus.veh_yellow), 32'h0);
    check("rst green", 32'(bus.veh_green), 32'h0);
    check("rst phase", 32'(bus.phase), 32'd2);
    check("rst dont_walk", 32'(bus.ped_dont_walk), 32'd1);
    check("rst tick", 32'(bus.tick), 32'd0);
    check("rst units", 32'(bus.cnt_units), 32'd2);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    run_table();

    // One-cycle pedestrian pulse during green[1].
    do_reset();
    run_to(45, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("ped pulse latched", 32'(bus.ped_pending), 32'd1);
    at_cycle(104, 1'b0, 1'b0);
    check("walk entry state", 32'(bus.state_code), 32'd4);
    check("walk entry lamp", 32'(bus.ped_walk), 32'd1);
    check("walk entry pending", 32'(bus.ped_pending), 32'd0);
    at_cycle(116, 1'b0, 1'b0);
    check("ped clr state", 32'(bus.state_code), 32'd5);
    at_cycle(120, 1'b0, 1'b0);
    check("after walk green", 32'(bus.veh_green), 32'h1);

    // Pedestrian request held through the walk.
    do_reset();
    run_to(45, 1'b0, 1'b0);
    at_cycle(104, 1'b1, 1'b0);
    check("hold walk pending", 32'(bus.ped_pending), 32'd0);
    at_cycle(116, 1'b1, 1'b0);
    check("hold clr first pending", 32'(bus.ped_pending), 32'd0);
    at_cycle(117, 1'b1, 1'b0);
    check("hold clr relatch", 32'(bus.ped_pending), 32'd1);
    run_to(130, 1'b0, 1'b0);

    // Night mode entry, flashing, and exit through all-red.
    do_reset();
    run_to(10, 1'b0, 1'b0);
    at_cycle(40, 1'b0, 1'b1);
    check("flash state", 32'(bus.state_code), 32'd6);
    check("flash yel on", 32'(bus.veh_yellow), 32'h7);
    check("flash tens blank", 32'(bus.cnt_tens), 32'hF);
    check("flash dont_walk", 32'(bus.ped_dont_walk), 32'd0);
    at_cycle(44, 1'b0, 1'b1);
    check("flash yel off", 32'(bus.veh_yellow), 32'h0);
    at_cycle(48, 1'b0, 1'b1);
    check("flash yel on again", 32'(bus.veh_yellow), 32'h7);
    run_to(50, 1'b0, 1'b1);
    at_cycle(52, 1'b0, 1'b0);
    check("flash exit state", 32'(bus.state_code), 32'd3);
    check("flash exit phase", 32'(bus.phase), 32'd2);
    at_cycle(56, 1'b0, 1'b0);
    check("flash exit green", 32'(bus.veh_green), 32'h1);

    // Random requests against the model.
    do_reset();
    night = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) night = ~night;
      ped = ($urandom_range(0, 11) == 0);
      applyStimulus(ped, night);
    end
    @(negedge clk);
    compare_model();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
